// File: rtl/tick_divider.sv
// Tick divider: counts enabled ticks modulo MODULO (up or down). It toggles a
// divided square wave and emits a one-cycle strobe on every wrap.
// Optional feature: define TICK_DIVIDER_LOAD_EN to add the loadEn/loadValue
// synchronous load ports. Without it, the priority is clear > tickIn > hold.
module tick_divider #(
   parameter int unsigned WIDTH  = 5,
   parameter int unsigned MODULO = 30
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             tickIn,
   input  logic             countDown,
   input  logic             clear,
`ifdef TICK_DIVIDER_LOAD_EN
   input  logic             loadEn,
   input  logic [WIDTH-1:0] loadValue,
`endif
   output logic [WIDTH-1:0] countOut,
   output logic             clockOut,
   output logic             terminalPulse
);

   // Highest legal count value; every wrap lands on 0 or on this value.
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

   // Reject parameter sets that cannot hold MODULO distinct counts.
   generate
      if ((MODULO < 2) || ((64'(1) << WIDTH) < 64'(MODULO))) begin : g_bad_params
         $fatal(1, "tick_divider: illegal parameters WIDTH=%0d MODULO=%0d", WIDTH, MODULO);
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic             phase_q, phase_d;
   logic             pulse_q, pulse_d;

   // Next-state logic: clear > load > tick > hold. The strobe defaults to low.
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      pulse_d = 1'b0;
      if (clear) begin
         count_d = '0;
         phase_d = 1'b0;
      end
`ifdef TICK_DIVIDER_LOAD_EN
      else if (loadEn) begin
         // Out-of-range load values saturate so the count never leaves range.
         count_d = (loadValue > MAX_CNT) ? MAX_CNT : loadValue;
      end
`endif
      else if (tickIn) begin
         if (countDown) begin
            if (count_q == '0) begin
               count_d = MAX_CNT;
               phase_d = ~phase_q;
               pulse_d = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end else begin
            if (count_q >= MAX_CNT) begin
               count_d = '0;
               phase_d = ~phase_q;
               pulse_d = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
         phase_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
         pulse_q <= pulse_d;
      end
   end

   assign countOut      = count_q;
   assign clockOut      = phase_q;
   assign terminalPulse = pulse_q;

endmodule

// File: tb/tb_tick_divider.sv
// Directed self-checking bench for tick_divider with default parameters.
module tb_tick_divider;

   localparam int unsigned WIDTH  = 5;
   localparam int unsigned MODULO = 30;

   logic             clock;
   logic             resetN;
   logic             tickIn;
   logic             countDown;
   logic             clear;
`ifdef TICK_DIVIDER_LOAD_EN
   logic             loadEn;
   logic [WIDTH-1:0] loadValue;
`endif
   logic [WIDTH-1:0] countOut;
   logic             clockOut;
   logic             terminalPulse;

   int checks = 0;
   int errors = 0;

   tick_divider #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
      .clock         (clock),
      .resetN        (resetN),
      .tickIn        (tickIn),
      .countDown     (countDown),
      .clear         (clear),
`ifdef TICK_DIVIDER_LOAD_EN
      .loadEn        (loadEn),
      .loadValue     (loadValue),
`endif
      .countOut      (countOut),
      .clockOut      (clockOut),
      .terminalPulse (terminalPulse)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance to 1 time unit past the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Bring the DUT back to count 0, phase 0 with a clear cycle.
   task automatic do_clear();
      clear  = 1'b1;
      tickIn = 1'b0;
      step();
      clear  = 1'b0;
   endtask

   task automatic test_reset();
      resetN = 1'b1;
      #2 resetN = 1'b0;
      #1;
      checks++;
      if (countOut !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", countOut); end
      checks++;
      if (clockOut !== 1'b0) begin errors++; $display("FAIL reset_clockOut got %b exp 0", clockOut); end
      checks++;
      if (terminalPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", terminalPulse); end
      // Inputs are ignored while reset is held.
      tickIn = 1'b1;
      step();
      step();
      checks++;
      if (countOut !== 5'd0) begin errors++; $display("FAIL reset_hold_count got %0d exp 0", countOut); end
      tickIn = 1'b0;
      resetN = 1'b1;
      step();
      checks++;
      if (countOut !== 5'd0) begin errors++; $display("FAIL reset_release_idle got %0d exp 0", countOut); end
   endtask

   task automatic test_up_count();
      int pulses;
      pulses    = 0;
      countDown = 1'b0;
      tickIn    = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (terminalPulse === 1'b1) pulses++;
         checks++;
         if (countOut !== 5'(k % 30)) begin
            errors++; $display("FAIL up_count cycle %0d got %0d exp %0d", k, countOut, k % 30);
         end
         checks++;
         if (terminalPulse !== ((k % 30) == 0)) begin
            errors++; $display("FAIL up_pulse cycle %0d got %b exp %b", k, terminalPulse, (k % 30) == 0);
         end
         checks++;
         if (clockOut !== 1'((k / 30) % 2)) begin
            errors++; $display("FAIL up_clockOut cycle %0d got %b exp %0d", k, clockOut, (k / 30) % 2);
         end
      end
      tickIn = 1'b0;
      checks++;
      if (pulses != 2) begin errors++; $display("FAIL up_pulse_total got %0d exp 2", pulses); end
   endtask

   task automatic test_down_and_direction();
      do_clear();
      countDown = 1'b1;
      tickIn    = 1'b1;
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd29, 1'b1, 1'b1}) begin
         errors++; $display("FAIL down_wrap got cnt=%0d p=%b c=%b exp cnt=29 p=1 c=1", countOut, terminalPulse, clockOut);
      end
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd28, 1'b0, 1'b1}) begin
         errors++; $display("FAIL down_second got cnt=%0d p=%b c=%b exp cnt=28 p=0 c=1", countOut, terminalPulse, clockOut);
      end
      tickIn = 1'b0;
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd28, 1'b0, 1'b1}) begin
         errors++; $display("FAIL hold got cnt=%0d p=%b c=%b exp cnt=28 p=0 c=1", countOut, terminalPulse, clockOut);
      end
      // Switching to up: the next tick moves up one with no wrap.
      countDown = 1'b0;
      tickIn    = 1'b1;
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd29, 1'b0, 1'b1}) begin
         errors++; $display("FAIL dir_change got cnt=%0d p=%b c=%b exp cnt=29 p=0 c=1", countOut, terminalPulse, clockOut);
      end
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL dir_up_wrap got cnt=%0d p=%b c=%b exp cnt=0 p=1 c=0", countOut, terminalPulse, clockOut);
      end
      tickIn = 1'b0;
   endtask

   task automatic test_clear();
      do_clear();
      countDown = 1'b1;
      tickIn    = 1'b1;
      step();
      checks++;
      if ({countOut, clockOut} !== {5'd29, 1'b1}) begin
         errors++; $display("FAIL clear_setup got cnt=%0d c=%b exp cnt=29 c=1", countOut, clockOut);
      end
      clear = 1'b1;
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL clear_priority got cnt=%0d p=%b c=%b exp cnt=0 p=0 c=0", countOut, terminalPulse, clockOut);
      end
      clear     = 1'b0;
      tickIn    = 1'b0;
      countDown = 1'b0;
   endtask

`ifdef TICK_DIVIDER_LOAD_EN
   task automatic test_load();
      do_clear();
      loadEn    = 1'b1;
      loadValue = 5'd31;
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd29, 1'b0, 1'b0}) begin
         errors++; $display("FAIL load_saturate got cnt=%0d p=%b c=%b exp cnt=29 p=0 c=0", countOut, terminalPulse, clockOut);
      end
      loadValue = 5'd12;
      tickIn    = 1'b1;
      step();
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd12, 1'b0, 1'b0}) begin
         errors++; $display("FAIL load_over_tick got cnt=%0d p=%b c=%b exp cnt=12 p=0 c=0", countOut, terminalPulse, clockOut);
      end
      loadEn = 1'b0;
      tickIn = 1'b0;
   endtask
`endif

   task automatic test_reset_midcount();
      int pulses;
      pulses = 0;
      do_clear();
      countDown = 1'b0;
      tickIn    = 1'b1;
      for (int k = 0; k < 17; k++) step();
      checks++;
      if (countOut !== 5'd17) begin errors++; $display("FAIL mid_setup got %0d exp 17", countOut); end
      #2 resetN = 1'b0;
      #1;
      checks++;
      if ({countOut, terminalPulse, clockOut} !== {5'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL mid_async got cnt=%0d p=%b c=%b exp all 0", countOut, terminalPulse, clockOut);
      end
      step();
      resetN = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (terminalPulse === 1'b1) pulses++;
      end
      tickIn = 1'b0;
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL mid_pulse_count got %0d exp 1", pulses); end
      checks++;
      if ({countOut, clockOut} !== {5'd0, 1'b1}) begin
         errors++; $display("FAIL mid_final got cnt=%0d c=%b exp cnt=0 c=1", countOut, clockOut);
      end
   endtask

   task automatic test_back_to_back_toggle();
      int pulses;
      int n;
      pulses = 0;
      n      = 0;
      do_clear();
      countDown = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tickIn = ((i % 2) == 0);
         step();
         if (tickIn) n++;
         if (terminalPulse === 1'b1) pulses++;
         checks++;
         if (countOut !== 5'(n % 30)) begin
            errors++; $display("FAIL toggle_count cycle %0d got %0d exp %0d", i, countOut, n % 30);
         end
         checks++;
         if (terminalPulse !== (tickIn && (n == 30))) begin
            errors++; $display("FAIL toggle_pulse cycle %0d got %b exp %b", i, terminalPulse, tickIn && (n == 30));
         end
      end
      tickIn = 1'b0;
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL toggle_pulse_total got %0d exp 1", pulses); end
   endtask

   initial begin
      resetN    = 1'b1;
      tickIn    = 1'b0;
      countDown = 1'b0;
      clear     = 1'b0;
`ifdef TICK_DIVIDER_LOAD_EN
      loadEn    = 1'b0;
      loadValue = '0;
`endif
      test_reset();
      test_up_count();
      test_down_and_direction();
      test_clear();
`ifdef TICK_DIVIDER_LOAD_EN
      test_load();
`endif
      test_reset_midcount();
      test_back_to_back_toggle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
